// File: rtl/fwd_hazard_unit.sv
// Decode/execute forwarding and load-use hazard unit: 3-level operand forwarding,
// LOAD_LAT-cycle stall/bubble sequencing and a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [DATA_W-1:0] rd1_data,
  input  logic [DATA_W-1:0] rd2_data,
  input  logic              ex_wb,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_wb,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wb,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

  typedef enum logic {RUN, HOLD} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            hz;
  logic            stall_c;
  logic [1:0]      sel1_raw, sel2_raw;

  // Youngest producer wins; a load in EX is never forwarded because the stall covers it.
  function automatic logic [1:0] pick(input logic [ADDR_W-1:0] rs,
                                      input logic e_wb, input logic e_ld,
                                      input logic [ADDR_W-1:0] e_rd,
                                      input logic m_wb, input logic [ADDR_W-1:0] m_rd,
                                      input logic w_wb, input logic [ADDR_W-1:0] w_rd);
    logic [1:0] s;
    s = 2'b00;
    if (!((ZERO_REG_EN != 0) && (rs == '0))) begin
      if (e_wb && !e_ld && (e_rd == rs))  s = 2'b01;
      else if (m_wb && (m_rd == rs))      s = 2'b10;
      else if (w_wb && (w_rd == rs))      s = 2'b11;
    end
    return s;
  endfunction

  always_comb begin
    sel1_raw = pick(rs1_addr, ex_wb, ex_is_load, ex_rd, mem_wb, mem_rd, wb_wb, wb_rd);
    sel2_raw = pick(rs2_addr, ex_wb, ex_is_load, ex_rd, mem_wb, mem_rd, wb_wb, wb_rd);
    fwd_sel1 = rst ? 2'b00 : sel1_raw;
    fwd_sel2 = rst ? 2'b00 : sel2_raw;
    case (fwd_sel1)
      2'b01:   op1 = ex_data;
      2'b10:   op1 = mem_data;
      2'b11:   op1 = wb_data;
      default: op1 = rd1_data;
    endcase
    case (fwd_sel2)
      2'b01:   op2 = ex_data;
      2'b10:   op2 = mem_data;
      2'b11:   op2 = wb_data;
      default: op2 = rd2_data;
    endcase
  end

  always_comb begin
    hz = id_valid && ex_wb && ex_is_load
         && !((ZERO_REG_EN != 0) && (ex_rd == '0))
         && ((rs1_used && (ex_rd == rs1_addr)) || (rs2_used && (ex_rd == rs2_addr)));
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          stall_c = hz;
          if (hz && (LOAD_LAT > 1)) begin
            state_nxt = HOLD;
            cnt_nxt   = CW'(LOAD_LAT - 1);
          end
        end
        HOLD: begin
          stall_c = 1'b1;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
    stall  = stall_c && !rst;
    bubble = stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: unit A (LOAD_LAT=1) and unit B
// (LOAD_LAT=3, ZERO_REG_EN=1, CNT_W=2) share inputs; directed vectors push expectations.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, rs1_used, rs2_used;
  logic [2:0]  rs1_addr, rs2_addr, ex_rd, mem_rd, wb_rd;
  logic [15:0] rd1_data, rd2_data, ex_data, mem_data, wb_data;
  logic        ex_wb, ex_is_load, mem_wb, wb_wb;

  logic [15:0] op1_a, op2_a, op1_b, op2_b;
  logic [1:0]  sel1_a, sel2_a, sel1_b, sel2_b;
  logic        stall_a, bubble_a, stall_b, bubble_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.DATA_W(16), .ADDR_W(3), .LOAD_LAT(1), .ZERO_REG_EN(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .ex_wb(ex_wb), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_wb(mem_wb), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wb(wb_wb), .wb_rd(wb_rd), .wb_data(wb_data),
    .op1(op1_a), .op2(op2_a), .fwd_sel1(sel1_a), .fwd_sel2(sel2_a),
    .stall(stall_a), .bubble(bubble_a), .stall_cnt(cnt_a));

  fwd_hazard_unit #(.DATA_W(16), .ADDR_W(3), .LOAD_LAT(3), .ZERO_REG_EN(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .ex_wb(ex_wb), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_wb(mem_wb), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wb(wb_wb), .wb_rd(wb_rd), .wb_data(wb_data),
    .op1(op1_b), .op2(op2_b), .fwd_sel1(sel1_b), .fwd_sel2(sel2_b),
    .stall(stall_b), .bubble(bubble_b), .stall_cnt(cnt_b));

  localparam int F_OP1 = 0, F_OP2 = 1, F_SEL1 = 2, F_SEL2 = 3, F_STALL = 4, F_BUB = 5, F_CNT = 6;
  localparam int UA = 0, UB = 1;

  typedef struct {
    int          unit;
    int          field;
    logic [31:0] expv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic string fname(input int f);
    case (f)
      F_OP1:   return "op1";
      F_OP2:   return "op2";
      F_SEL1:  return "fwd_sel1";
      F_SEL2:  return "fwd_sel2";
      F_STALL: return "stall";
      F_BUB:   return "bubble";
      default: return "stall_cnt";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int u, input int f);
    if (u == UA) begin
      case (f)
        F_OP1:   return 32'(op1_a);
        F_OP2:   return 32'(op2_a);
        F_SEL1:  return 32'(sel1_a);
        F_SEL2:  return 32'(sel2_a);
        F_STALL: return 32'(stall_a);
        F_BUB:   return 32'(bubble_a);
        default: return 32'(cnt_a);
      endcase
    end else begin
      case (f)
        F_OP1:   return 32'(op1_b);
        F_OP2:   return 32'(op2_b);
        F_SEL1:  return 32'(sel1_b);
        F_SEL2:  return 32'(sel2_b);
        F_STALL: return 32'(stall_b);
        F_BUB:   return 32'(bubble_b);
        default: return 32'(cnt_b);
      endcase
    end
  endfunction

  task automatic exp(input int u, input int f, input logic [31:0] v);
    exp_t e;
    e.unit  = u;
    e.field = f;
    e.expv  = v;
    sb.push_back(e);
  endtask

  // Monitor: outputs are settled mid-cycle, so every queued expectation is checked at negedge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = actual(e.unit, e.field);
      checks++;
      if (act !== e.expv) begin
        errors++;
        $display("FAIL %s unit=%s got=%0h want=%0h", fname(e.field),
                 (e.unit == UA) ? "A" : "B", act, e.expv);
      end
    end
  end

  task automatic idle();
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    rd1_data = '0; rd2_data = '0;
    ex_wb = 1'b0; ex_is_load = 1'b0; ex_rd = '0; ex_data = '0;
    mem_wb = 1'b0; mem_rd = '0; mem_data = '0;
    wb_wb = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hazard_r3();
    idle();
    ex_wb = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd3; ex_data = 16'hDEAD;
    rs1_addr = 3'd3; rs1_used = 1'b1; id_valid = 1'b1; rd1_data = 16'h0101;
  endtask

  initial begin
    idle();
    tick();

    // Reset: hazard-looking inputs must be masked, operands come from the register file.
    rst = 1'b1; rd1_data = 16'hAAAA; rd2_data = 16'h5555;
    ex_wb = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd1; rs1_addr = 3'd1; rs1_used = 1'b1;
    id_valid = 1'b1; mem_wb = 1'b1; mem_rd = 3'd0;
    exp(UA, F_STALL, 0); exp(UA, F_BUB, 0); exp(UA, F_SEL1, 0);
    exp(UA, F_OP1, 16'hAAAA); exp(UA, F_OP2, 16'h5555); exp(UB, F_STALL, 0);
    exp(UB, F_SEL2, 0);
    tick();
    exp(UA, F_CNT, 0); exp(UB, F_CNT, 0); exp(UB, F_STALL, 0);
    tick();

    // EX beats MEM beats WB.
    idle();
    rs1_addr = 3'd2; rs1_used = 1'b1; id_valid = 1'b1; rd1_data = 16'h0101;
    ex_wb = 1'b1; ex_rd = 3'd2; ex_data = 16'h1234;
    mem_wb = 1'b1; mem_rd = 3'd2; mem_data = 16'h2222;
    exp(UA, F_OP1, 16'h1234); exp(UA, F_SEL1, 1); exp(UA, F_STALL, 0); exp(UB, F_SEL1, 1);
    tick();
    ex_wb = 1'b0;
    exp(UA, F_OP1, 16'h2222); exp(UA, F_SEL1, 2);
    tick();
    mem_wb = 1'b0; wb_wb = 1'b1; wb_rd = 3'd2; wb_data = 16'h3333;
    exp(UA, F_OP1, 16'h3333); exp(UA, F_SEL1, 3);
    tick();

    // WB-only match on rs2; load in EX to r5 neither forwards nor stalls when rs2 is unused.
    idle();
    rs2_addr = 3'd5; id_valid = 1'b1; rd2_data = 16'h0202;
    wb_wb = 1'b1; wb_rd = 3'd5; wb_data = 16'hBEEF;
    ex_wb = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd5; ex_data = 16'h1111;
    exp(UA, F_OP2, 16'hBEEF); exp(UA, F_SEL2, 3); exp(UA, F_STALL, 0); exp(UB, F_STALL, 0);
    tick();
    ex_wb = 1'b0; ex_is_load = 1'b0; rs2_used = 1'b1;
    exp(UA, F_OP2, 16'hBEEF); exp(UA, F_SEL2, 3); exp(UA, F_STALL, 0);
    tick();

    // LOAD_LAT=1 load-use: one stall cycle, then the load result arrives from MEM.
    load_hazard_r3();
    exp(UA, F_STALL, 1); exp(UA, F_BUB, 1); exp(UA, F_SEL1, 0);
    exp(UA, F_OP1, 16'h0101); exp(UA, F_CNT, 0); exp(UB, F_STALL, 1);
    tick();
    ex_wb = 1'b0; ex_is_load = 1'b0; mem_wb = 1'b1; mem_rd = 3'd3; mem_data = 16'h7777;
    exp(UA, F_STALL, 0); exp(UA, F_BUB, 0); exp(UA, F_SEL1, 2);
    exp(UA, F_OP1, 16'h7777); exp(UA, F_CNT, 1); exp(UB, F_STALL, 1);
    tick();
    exp(UA, F_STALL, 0); exp(UA, F_CNT, 1); exp(UB, F_STALL, 1);
    tick();
    idle(); rst = 1'b1;
    tick();

    // LOAD_LAT=3 hazard, flush in the second stall cycle.
    load_hazard_r3();
    exp(UB, F_STALL, 1); exp(UB, F_CNT, 0);
    tick();
    flush = 1'b1;
    exp(UB, F_STALL, 0); exp(UB, F_BUB, 0); exp(UB, F_CNT, 1); exp(UA, F_STALL, 0);
    tick();
    idle();
    exp(UB, F_STALL, 0); exp(UB, F_CNT, 1);
    tick();
    idle(); rst = 1'b1;
    tick();

    // Held hazard on B: five stall cycles saturate the 2-bit counter, then reset aborts HOLD.
    for (int i = 0; i < 5; i++) begin
      load_hazard_r3();
      exp(UB, F_STALL, 1);
      exp(UB, F_CNT, (i > 3) ? 3 : i);
      tick();
    end
    rst = 1'b1;
    exp(UB, F_STALL, 0); exp(UB, F_BUB, 0); exp(UB, F_CNT, 3);
    tick();
    idle();
    exp(UB, F_STALL, 0); exp(UB, F_CNT, 0);
    tick();

    // Register 0: hard-wired on B (no stall, no forward), ordinary register on A.
    idle();
    rs1_addr = 3'd0; rs1_used = 1'b1; id_valid = 1'b1; rd1_data = 16'h4242;
    ex_wb = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd0; ex_data = 16'h9999;
    mem_wb = 1'b1; mem_rd = 3'd0; mem_data = 16'h8888;
    exp(UB, F_STALL, 0); exp(UB, F_OP1, 16'h4242); exp(UB, F_SEL1, 0);
    exp(UA, F_STALL, 1); exp(UA, F_SEL1, 2); exp(UA, F_OP1, 16'h8888);
    tick();

    idle();
    tick();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
